// File: rtl/div_share_arb.sv
// div_share_arb: round-robin front end that shares one two-stage restoring divider
// among NREQ requesters, with per-requester result holding registers.

// Two-stage restoring divider: (K+32)-bit dividend / K-bit divisor -> K-bit q, r.
// Stage 1 resolves the upper quotient bits, stage 2 the lower ones.
// The quotient is only meaningful when x[K+31:K] < d.
module div_share_core #(
    parameter int unsigned K = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [K+31:0] x,
    input  logic [K-1:0]  d,
    output logic [K-1:0]  q,
    output logic [K-1:0]  r
);
    localparam int unsigned LO = K / 2;
    localparam int unsigned HI = K - LO;

    logic [K-1:0]  s1_rem_c, s1_rem, s1_d;
    logic [HI-1:0] s1_q_c, s1_q;
    logic [LO-1:0] s1_xlo;
    logic [K-1:0]  s2_rem_c;
    logic [LO-1:0] s2_q_c;
    logic [K:0]    t1, t2;

    // Stage 1: shift in the upper dividend bits of the low word.
    always_comb begin
        s1_rem_c = K'(x[K+31:K]);
        s1_q_c   = '0;
        t1       = '0;
        for (int i = int'(K) - 1; i >= int'(LO); i--) begin
            t1 = {s1_rem_c, x[i]};
            if (t1 >= {1'b0, d}) begin
                t1 = t1 - {1'b0, d};
                s1_q_c[i - int'(LO)] = 1'b1;
            end
            s1_rem_c = t1[K-1:0];
        end
    end

    // Stage 1 pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_rem <= '0;
            s1_q   <= '0;
            s1_xlo <= '0;
            s1_d   <= '0;
        end else begin
            s1_rem <= s1_rem_c;
            s1_q   <= s1_q_c;
            s1_xlo <= x[LO-1:0];
            s1_d   <= d;
        end
    end

    // Stage 2: finish the remaining dividend bits.
    always_comb begin
        s2_rem_c = s1_rem;
        s2_q_c   = '0;
        t2       = '0;
        for (int i = int'(LO) - 1; i >= 0; i--) begin
            t2 = {s2_rem_c, s1_xlo[i]};
            if (t2 >= {1'b0, s1_d}) begin
                t2 = t2 - {1'b0, s1_d};
                s2_q_c[i] = 1'b1;
            end
            s2_rem_c = t2[K-1:0];
        end
    end

    // Quotient / remainder output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
            r <= '0;
        end else begin
            q <= {s1_q, s2_q_c};
            r <= s2_rem_c;
        end
    end
endmodule

module div_share_arb #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned K    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*(K+32)-1:0] req_x,
    input  logic [NREQ*K-1:0]      req_d,
    output logic [NREQ-1:0]        rsp_valid,
    input  logic [NREQ-1:0]        rsp_ready,
    output logic [NREQ*K-1:0]      rsp_q,
    output logic [NREQ*K-1:0]      rsp_r,
    output logic [NREQ-1:0]        rsp_dz,
    output logic [NREQ-1:0]        rsp_ovf,
    output logic                   busy,
    output logic [31:0]            ops_done
);
    localparam int unsigned XW  = K + 32;
    localparam int unsigned PW  = $clog2(NREQ);
    localparam int unsigned LAT = 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_INFL = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      state     [NREQ];
    logic [1:0]      state_nxt [NREQ];
    logic [NREQ-1:0] idle_vec, elig, hs;
    logic [PW-1:0]   ptr, gidx, cand;
    logic            grant_any;
    logic [XW-1:0]   x_sel;
    logic [K-1:0]    d_sel;
    logic            sel_dz, sel_ovf;
    logic            core_rst_n;
    logic [K-1:0]    core_q, core_r;
    logic            tag_v   [LAT];
    logic [PW-1:0]   tag_id  [LAT];
    logic            tag_dz  [LAT];
    logic            tag_ovf [LAT];
    logic [K-1:0]    res_q [NREQ];
    logic [K-1:0]    res_r [NREQ];
    logic [NREQ-1:0] res_dz, res_ovf;
    logic [31:0]     hs_cnt;

    // Per-requester status decode; nothing is eligible while in reset.
    always_comb begin
        idle_vec  = '0;
        rsp_valid = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            idle_vec[i]  = (state[i] == S_IDLE);
            rsp_valid[i] = (state[i] == S_DONE);
        end
        busy = ~&idle_vec;
        elig = req_valid & idle_vec & {NREQ{~rst}};
        hs   = rsp_valid & rsp_ready;
    end

    // Round-robin grant: first eligible requester at or after ptr.
    always_comb begin
        grant_any = 1'b0;
        gidx      = '0;
        cand      = '0;
        req_ready = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            cand = PW'((int'(ptr) + k) % int'(NREQ));
            if (!grant_any && elig[cand]) begin
                grant_any = 1'b1;
                gidx      = cand;
            end
        end
        if (grant_any) req_ready[gidx] = 1'b1;
    end

    // Operand mux for the granted requester and accept-time flags.
    always_comb begin
        x_sel   = req_x[int'(gidx)*int'(XW) +: XW];
        d_sel   = req_d[int'(gidx)*int'(K) +: K];
        sel_dz  = (d_sel == '0);
        sel_ovf = !sel_dz && (XW'(x_sel[XW-1:K]) >= XW'(d_sel));
    end

    // Round-robin pointer advances past the winner only on an accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant_any) begin
            ptr <= (int'(gidx) == int'(NREQ) - 1) ? '0 : gidx + PW'(1);
        end
    end

    assign core_rst_n = ~rst;

    div_share_core #(.K(K)) u_core (
        .clk   (clk),
        .rst_n (core_rst_n),
        .x     (x_sel),
        .d     (d_sel),
        .q     (core_q),
        .r     (core_r)
    );

    // Tag pipe travels alongside the core so the result knows its owner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int l = 0; l < int'(LAT); l++) begin
                tag_v[l]   <= 1'b0;
                tag_id[l]  <= '0;
                tag_dz[l]  <= 1'b0;
                tag_ovf[l] <= 1'b0;
            end
        end else begin
            tag_v[0]   <= grant_any;
            tag_id[0]  <= gidx;
            tag_dz[0]  <= sel_dz;
            tag_ovf[0] <= sel_ovf;
            for (int l = 1; l < int'(LAT); l++) begin
                tag_v[l]   <= tag_v[l-1];
                tag_id[l]  <= tag_id[l-1];
                tag_dz[l]  <= tag_dz[l-1];
                tag_ovf[l] <= tag_ovf[l-1];
            end
        end
    end

    // Result holding registers load when the tag exits the pipe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                res_q[i] <= '0;
                res_r[i] <= '0;
            end
            res_dz  <= '0;
            res_ovf <= '0;
        end else if (tag_v[LAT-1]) begin
            res_q[tag_id[LAT-1]]   <= tag_dz[LAT-1] ? '1 : core_q;
            res_r[tag_id[LAT-1]]   <= tag_dz[LAT-1] ? '0 : core_r;
            res_dz[tag_id[LAT-1]]  <= tag_dz[LAT-1];
            res_ovf[tag_id[LAT-1]] <= tag_ovf[LAT-1];
        end
    end

    // Flatten holding registers onto the response buses.
    always_comb begin
        rsp_q = '0;
        rsp_r = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            rsp_q[i*int'(K) +: K] = res_q[i];
            rsp_r[i*int'(K) +: K] = res_r[i];
        end
        rsp_dz  = res_dz;
        rsp_ovf = res_ovf;
    end

    // Per-requester state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREQ); i++) state[i] <= S_IDLE;
        end else begin
            for (int i = 0; i < int'(NREQ); i++) state[i] <= state_nxt[i];
        end
    end

    // Per-requester next state: accept, tag return, response handshake.
    always_comb begin
        for (int i = 0; i < int'(NREQ); i++) begin
            state_nxt[i] = state[i];
            case (state[i])
                S_IDLE: if (req_ready[i]) state_nxt[i] = S_INFL;
                S_INFL: if (tag_v[LAT-1] && tag_id[LAT-1] == PW'(i)) state_nxt[i] = S_DONE;
                S_DONE: if (rsp_ready[i]) state_nxt[i] = S_IDLE;
                default: state_nxt[i] = S_IDLE;
            endcase
        end
    end

    // Handshakes completed this cycle.
    always_comb begin
        hs_cnt = '0;
        for (int i = 0; i < int'(NREQ); i++) hs_cnt = hs_cnt + 32'(hs[i]);
    end

    // Completed-response counter, wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ops_done <= '0;
        end else begin
            ops_done <= ops_done + hs_cnt;
        end
    end
endmodule

// File: tb/tb_div_share_arb.sv
// tb_div_share_arb: directed bench with a transaction-level model of the shared divider.
`timescale 1ns/1ps
module tb_div_share_arb;
    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid, req_ready, rsp_valid, rsp_ready, rsp_dz, rsp_ovf;
    logic [255:0] req_x;
    logic [127:0] req_d, rsp_q, rsp_r;
    logic         busy;
    logic [31:0]  ops_done;

    int total = 0;
    int bad   = 0;

    // Model: 0 idle, 1 in flight, 2 result held.
    int          m_st  [4];
    int          m_cnt [4];
    logic [31:0] m_q   [4];
    logic [31:0] m_r   [4];
    logic        m_dz  [4];
    logic        m_ovf [4];
    int          m_ptr;
    int unsigned m_ops;
    logic [3:0]      mdl_g;
    longint unsigned mdl_x, mdl_d;
    int n0;

    div_share_arb #(.NREQ(4), .K(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_d(req_d),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_q(rsp_q), .rsp_r(rsp_r), .rsp_dz(rsp_dz), .rsp_ovf(rsp_ovf),
        .busy(busy), .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    function automatic logic [3:0] exp_grant();
        logic [3:0] g;
        g = '0;
        for (int k = 0; k < 4; k++) begin
            automatic int idx = (m_ptr + k) % 4;
            if (req_valid[idx] && m_st[idx] == 0) begin
                g[idx] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    // Transaction model: accept, 2-edge latency, hold until handshake.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_st[i] = 0; m_cnt[i] = 0;
            end
            m_ptr = 0;
            m_ops = 0;
        end else begin
            mdl_g = exp_grant();
            for (int i = 0; i < 4; i++) begin
                if (m_st[i] == 2 && rsp_ready[i]) begin
                    m_st[i] = 0;
                    m_ops   = m_ops + 1;
                end else if (m_st[i] == 1) begin
                    m_cnt[i] = m_cnt[i] + 1;
                    if (m_cnt[i] == 2) m_st[i] = 2;
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (mdl_g[i]) begin
                    mdl_x    = req_x[i*64 +: 64];
                    mdl_d    = 64'(req_d[i*32 +: 32]);
                    m_st[i]  = 1;
                    m_cnt[i] = 0;
                    if (mdl_d == 0) begin
                        m_q[i] = 32'hFFFF_FFFF; m_r[i] = 32'h0;
                        m_dz[i] = 1'b1; m_ovf[i] = 1'b0;
                    end else begin
                        m_q[i]   = 32'(mdl_x / mdl_d);
                        m_r[i]   = 32'(mdl_x % mdl_d);
                        m_dz[i]  = 1'b0;
                        m_ovf[i] = ((mdl_x >> 32) >= mdl_d);
                    end
                    m_ptr = (i + 1) % 4;
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    task automatic compare();
        logic [3:0] dv;
        if (rst) begin
            check("rst_req_ready", 64'(req_ready), 0);
            check("rst_rsp_valid", 64'(rsp_valid), 0);
            check("rst_busy", 64'(busy), 0);
            check("rst_ops_done", 64'(ops_done), 0);
            check("rst_rsp_q", 64'(|rsp_q), 0);
            check("rst_rsp_r", 64'(|rsp_r), 0);
            check("rst_flags", 64'({rsp_dz, rsp_ovf}), 0);
        end else begin
            dv = '0;
            for (int i = 0; i < 4; i++) dv[i] = (m_st[i] == 2);
            check("req_ready", 64'(req_ready), 64'(exp_grant()));
            check("rsp_valid", 64'(rsp_valid), 64'(dv));
            check("busy", 64'(busy), 64'(m_st[0] != 0 || m_st[1] != 0 || m_st[2] != 0 || m_st[3] != 0));
            check("ops_done", 64'(ops_done), 64'(m_ops));
            for (int i = 0; i < 4; i++) begin
                if (m_st[i] == 2) begin
                    check($sformatf("dz%0d", i), 64'(rsp_dz[i]), 64'(m_dz[i]));
                    check($sformatf("ovf%0d", i), 64'(rsp_ovf[i]), 64'(m_ovf[i]));
                    if (!m_ovf[i]) begin
                        check($sformatf("q%0d", i), 64'(rsp_q[i*32 +: 32]), 64'(m_q[i]));
                        check($sformatf("r%0d", i), 64'(rsp_r[i*32 +: 32]), 64'(m_r[i]));
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [63:0] x, input logic [31:0] d);
        req_x[i*64 +: 64] = x;
        req_d[i*32 +: 32] = d;
    endtask

    task automatic wait_accept(input int i);
        int n;
        n = 0;
        while (!req_ready[i] && n < 40) begin
            step();
            n++;
        end
        if (n >= 40) check($sformatf("accept_timeout%0d", i), 0, 1);
        else step();
    endtask

    task automatic issue(input int i, input logic [63:0] x, input logic [31:0] d);
        set_op(i, x, d);
        req_valid[i] = 1'b1;
        #1;
        wait_accept(i);
        req_valid[i] = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_x = '0; req_d = '0; rsp_ready = 4'hF;
        step(); step();
        check("reset_ops_done", 64'(ops_done), 0);
        check("reset_busy", 64'(busy), 0);
        rst = 1'b0;
        step();

        // 1: 100 / 7
        issue(0, 64'd100, 32'd7);
        step(); step();
        check("t1_valid", 64'(rsp_valid[0]), 1);
        check("t1_q", 64'(rsp_q[31:0]), 14);
        check("t1_r", 64'(rsp_r[31:0]), 2);
        step();
        check("t1_ops_done", 64'(ops_done), 1);

        // 2: upper-word dividend
        issue(0, 64'h0000_0005_0000_0000, 32'h10);
        step(); step();
        check("t2_q", 64'(rsp_q[31:0]), 64'h5000_0000);
        check("t2_r", 64'(rsp_r[31:0]), 0);
        check("t2_flags", 64'({rsp_dz[0], rsp_ovf[0]}), 0);
        step();

        // 3: all four requesters from reset
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < 4; i++) set_op(i, 64'(1000 * (i + 1)), 32'(i + 3));
        req_valid = 4'hF;
        #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t3_grant%0d", k), 64'(req_ready), 64'(4'b0001 << k));
            step();
            req_valid[k] = 1'b0;
            if (k >= 2) check($sformatf("t3_rsp%0d", k - 2), 64'(rsp_valid), 64'(4'b0001 << (k - 2)));
        end
        step();
        check("t3_rsp2", 64'(rsp_valid), 64'b0100);
        step();
        check("t3_rsp3", 64'(rsp_valid), 64'b1000);
        check("t3_q3", 64'(rsp_q[127:96]), 666);
        step(); step();

        // 4: divide by zero and overflow
        issue(2, 64'd12345, 32'd0);
        step(); step();
        check("t4_dz", 64'(rsp_dz[2]), 1);
        check("t4_dz_q", 64'(rsp_q[95:64]), 64'hFFFF_FFFF);
        check("t4_dz_r", 64'(rsp_r[95:64]), 0);
        check("t4_dz_ovf", 64'(rsp_ovf[2]), 0);
        step();
        issue(3, 64'h0000_0010_0000_0000, 32'h10);
        step(); step();
        check("t4_ovf", 64'(rsp_ovf[3]), 1);
        check("t4_ovf_dz", 64'(rsp_dz[3]), 0);
        step();

        // 5: requester 1 stalls its response for 10 cycles
        rsp_ready = 4'b1101;
        issue(1, 64'd1000000, 32'd3);
        step(); step();
        set_op(1, 64'd2000, 32'd9);
        set_op(0, 64'd777, 32'd7);
        req_valid = 4'b0011;
        #1;
        n0 = 0;
        for (int c = 0; c < 10; c++) begin
            check("t5_hold_valid", 64'(rsp_valid[1]), 1);
            check("t5_hold_q", 64'(rsp_q[63:32]), 333333);
            check("t5_hold_r", 64'(rsp_r[63:32]), 1);
            check("t5_ready1", 64'(req_ready[1]), 0);
            n0 += int'(req_ready[0]);
            step();
        end
        check("t5_others_served", 64'(n0 >= 2), 1);
        req_valid[0] = 1'b0;
        rsp_ready = 4'hF;
        #1;
        wait_accept(1);
        req_valid[1] = 1'b0;
        step(); step();
        check("t5_q_new", 64'(rsp_q[63:32]), 222);
        check("t5_r_new", 64'(rsp_r[63:32]), 2);
        step(); step(); step();

        // 6: reset one cycle after an accept
        issue(2, 64'd500, 32'd5);
        step();
        rst = 1'b1;
        #1;
        check("t6_rst_valid", 64'(rsp_valid), 0);
        check("t6_rst_busy", 64'(busy), 0);
        check("t6_rst_ops", 64'(ops_done), 0);
        step(); step();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            check("t6_no_rsp", 64'(rsp_valid), 0);
        end
        issue(2, 64'd500, 32'd5);
        step(); step();
        check("t6_valid", 64'(rsp_valid[2]), 1);
        check("t6_q", 64'(rsp_q[95:64]), 100);
        check("t6_r", 64'(rsp_r[95:64]), 0);
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
